// File: rtl/fetch_unit.sv
// Instruction fetch for a 1-cycle synchronous imem: tags words with their address, resolves J-type jumps locally.
// Redirect/jump cost one bubble; stall holds the output by re-reading the same word.
module fetch_unit #(
   parameter logic [7:0] RESET_PC = 8'h00,
   parameter logic [5:0] J_OPCODE = 6'b000010
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        stall,
   input  logic        redirect_valid,
   input  logic [7:0]  redirect_addr,
   input  logic [31:0] imem_q,
   output logic [7:0]  imem_addr,
   output logic [31:0] instr,
   output logic [7:0]  instr_pc,
   output logic        instr_valid,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {BOOT, RUN, SQUASH} state_t;

   state_t      state_q, state_d;
   logic [7:0]  pc_q, pc_d;
   logic [7:0]  tag_q, tag_d;
   logic [15:0] cnt_q, cnt_d;
   logic        hold;
   logic        accept;
   logic        jump;

   // imem_addr is built from registers and control inputs only, never from imem_q.
   assign hold        = (state_q == RUN) & stall & ~redirect_valid;
   assign imem_addr   = hold ? tag_q : pc_q;
   assign instr_valid = (state_q == RUN);
   assign instr       = imem_q;
   assign instr_pc    = tag_q;
   assign fetch_count = cnt_q;
   assign accept      = instr_valid & ~stall;
   assign jump        = accept & (imem_q[31:26] == J_OPCODE);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      tag_d   = tag_q;
      cnt_d   = cnt_q;
      if (accept) begin
         cnt_d = cnt_q + 16'd1;
      end
      if (!hold) begin
         tag_d = imem_addr;
         if (redirect_valid) begin
            pc_d = redirect_addr;
         end else if (jump) begin
            pc_d = imem_q[7:0];
         end else begin
            pc_d = pc_q + 8'd1;
         end
         case (state_q)
            BOOT:    state_d = redirect_valid ? SQUASH : RUN;
            RUN:     state_d = (redirect_valid | jump) ? SQUASH : RUN;
            SQUASH:  state_d = redirect_valid ? SQUASH : RUN;
            default: state_d = BOOT;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= BOOT;
         pc_q    <= RESET_PC;
         tag_q   <= RESET_PC;
         cnt_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         tag_q   <= tag_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: scoreboard of accepted (pc, instr) pairs plus directed cycle checks.
module tb_fetch_unit;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        stall;
   logic        redirect_valid;
   logic [7:0]  redirect_addr;
   logic [31:0] imem_q;
   logic [7:0]  imem_addr;
   logic [31:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic [15:0] fetch_count;

   logic        rst2_n;
   logic [31:0] imem2_q;
   logic [7:0]  b_imem_addr;
   logic [31:0] b_instr;
   logic [7:0]  b_instr_pc;
   logic        b_instr_valid;
   logic [15:0] b_fetch_count;

   logic [31:0] mem [0:255];

   typedef struct packed {
      logic [7:0]  pc;
      logic [31:0] ins;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;

   always #5 clock = ~clock;

   fetch_unit #(.RESET_PC(8'h00)) dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .stall          (stall),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_q         (imem_q),
      .imem_addr      (imem_addr),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_valid    (instr_valid),
      .fetch_count    (fetch_count)
   );

   fetch_unit #(.RESET_PC(8'hFE)) dut_wrap (
      .clock          (clock),
      .reset_n        (rst2_n),
      .stall          (1'b0),
      .redirect_valid (1'b0),
      .redirect_addr  (8'h00),
      .imem_q         (imem2_q),
      .imem_addr      (b_imem_addr),
      .instr          (b_instr),
      .instr_pc       (b_instr_pc),
      .instr_valid    (b_instr_valid),
      .fetch_count    (b_fetch_count)
   );

   always @(posedge clock) imem_q  <= mem[imem_addr];
   always @(posedge clock) imem2_q <= 32'h0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic expect_pc(input logic [7:0] pc);
      exp_t e;
      e.pc  = pc;
      e.ins = mem[pc];
      exp_q.push_back(e);
   endtask

   // One clock cycle: drive at the falling edge, sample 1ns later, score accepted words.
   task automatic cycle(input logic st, input logic rv, input logic [7:0] ra);
      exp_t e;
      @(negedge clock);
      stall          = st;
      redirect_valid = rv;
      redirect_addr  = ra;
      #1;
      if (instr_valid && !stall) begin
         if (exp_q.size() == 0) begin
            check_eq("sb_unexpected", 32'(exp_q.size()), 32'd1);
         end else begin
            e = exp_q.pop_front();
            check_eq("sb_pc", 32'(instr_pc), 32'(e.pc));
            check_eq("sb_instr", instr, e.ins);
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] w;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h8C0100FF;
      mem[1] = 32'hAC010009;
      mem[2] = 32'h8C020009;
      mem[3] = 32'hAC0200FF;
      mem[4] = 32'h08000000;
      stall = 1'b0; redirect_valid = 1'b0; redirect_addr = 8'h00;
      reset_n = 1'b1; rst2_n = 1'b1;
      #1;
      reset_n = 1'b0; rst2_n = 1'b0;

      @(negedge clock); #1;
      check_eq("rst_valid", 32'(instr_valid), 32'd0);
      check_eq("rst_imem_addr", 32'(imem_addr), 32'h00);
      check_eq("rst_instr_pc", 32'(instr_pc), 32'h00);
      check_eq("rst_fetch_count", 32'(fetch_count), 32'd0);
      check_eq("rst_wrap_addr", 32'(b_imem_addr), 32'hFE);
      check_eq("rst_wrap_valid", 32'(b_instr_valid), 32'd0);
      @(negedge clock);
      reset_n = 1'b1; rst2_n = 1'b1;

      // Two passes through the looping image, no stall.
      for (int p = 0; p < 2; p++)
         for (int j = 0; j < 5; j++) expect_pc(8'(j));
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 1'b0, 8'h00);
         w = 8'hFE + 8'(i);
         check_eq("wrap_valid", 32'(b_instr_valid), 32'd1);
         check_eq("wrap_pc", 32'(b_instr_pc), 32'(w));
      end
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("jump_bubble_valid", 32'(instr_valid), 32'd0);
      check_eq("jump_bubble_addr", 32'(imem_addr), 32'h00);
      repeat (5) cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("loop2_bubble", 32'(instr_valid), 32'd0);
      check_eq("loop2_count", 32'(fetch_count), 32'd10);
      check_eq("loop2_drained", 32'(exp_q.size()), 32'd0);

      // Stall three cycles on instr_pc=2.
      for (int j = 0; j < 5; j++) expect_pc(8'(j));
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b0, 8'h00);
         check_eq("stall_instr", instr, 32'h8C020009);
         check_eq("stall_pc", 32'(instr_pc), 32'h02);
         check_eq("stall_valid", 32'(instr_valid), 32'd1);
         check_eq("stall_imem_addr", 32'(imem_addr), 32'h02);
      end
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("stall_release_instr", instr, 32'h8C020009);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("after_stall_pc", 32'(instr_pc), 32'h03);

      // Stall on the J word: no jump while held.
      for (int i = 0; i < 2; i++) begin
         cycle(1'b1, 1'b0, 8'h00);
         check_eq("jstall_valid", 32'(instr_valid), 32'd1);
         check_eq("jstall_pc", 32'(instr_pc), 32'h04);
         check_eq("jstall_imem_addr", 32'(imem_addr), 32'h04);
      end
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("jstall_bubble", 32'(instr_valid), 32'd0);
      check_eq("jstall_target", 32'(imem_addr), 32'h00);

      // Redirect to 3 while instr_pc=1 is stalled.
      expect_pc(8'h00); expect_pc(8'h03); expect_pc(8'h04);
      expect_pc(8'h00); expect_pc(8'h01); expect_pc(8'h02); expect_pc(8'h03);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b1, 1'b1, 8'h03);
      check_eq("redir_pc_seen", 32'(instr_pc), 32'h01);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("redir_bubble", 32'(instr_valid), 32'd0);
      check_eq("redir_addr", 32'(imem_addr), 32'h03);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("redir_target_pc", 32'(instr_pc), 32'h03);
      check_eq("redir_target_instr", instr, 32'hAC0200FF);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      repeat (3) cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("pre_reset_pc", 32'(instr_pc), 32'h03);

      // Asynchronous reset mid-stream.
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_valid", 32'(instr_valid), 32'd0);
      check_eq("mid_rst_addr", 32'(imem_addr), 32'h00);
      check_eq("mid_rst_count", 32'(fetch_count), 32'd0);
      check_eq("mid_rst_pc", 32'(instr_pc), 32'h00);
      @(negedge clock);
      reset_n = 1'b1;

      // Restart, then back-to-back redirects (1 then 4): only 4 delivered.
      expect_pc(8'h00); expect_pc(8'h01); expect_pc(8'h02);
      expect_pc(8'h04); expect_pc(8'h00);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("restart_pc", 32'(instr_pc), 32'h00);
      cycle(1'b0, 1'b0, 8'h00);
      cycle(1'b0, 1'b1, 8'h01);
      check_eq("restart_count", 32'(fetch_count), 32'd2);
      cycle(1'b0, 1'b1, 8'h04);
      check_eq("b2b_bubble1", 32'(instr_valid), 32'd0);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("b2b_bubble2", 32'(instr_valid), 32'd0);
      check_eq("b2b_addr", 32'(imem_addr), 32'h04);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("b2b_target_pc", 32'(instr_pc), 32'h04);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("b2b_jump_bubble", 32'(instr_valid), 32'd0);
      cycle(1'b0, 1'b0, 8'h00);
      check_eq("final_pc", 32'(instr_pc), 32'h00);
      check_eq("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
